// File: rtl/fmap_stream_pkg.sv
// ---------------------------------------------------------------------------
// fmap_stream_pkg
//
// Shared definitions for the feature-map stream source.
//   state_t   : FSM states of the streamer (IDLE, READ, GAP, DRAIN, FLUSH)
//   cntWidth  : width for the raster / gap counters, sized so the largest of
//               NW, NH and ROW_GAP+1 distinct values fits (never below 1 bit)
// ---------------------------------------------------------------------------
package fmap_stream_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_GAP,
      ST_DRAIN,
      ST_FLUSH
   } state_t;

   // ceil(log2(max(nw, nh, rowGap+1))), clamped to at least one bit so a
   // degenerate 1x1 frame with no gap still yields a legal vector width.
   function automatic int cntWidth(input int nw, input int nh, input int rowGap);
      int m;
      int w;
      m = nw;
      if (nh > m) begin
         m = nh;
      end
      if ((rowGap + 1) > m) begin
         m = rowGap + 1;
      end
      w = 0;
      while ((1 << w) < m) begin
         w = w + 1;
      end
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/fmap_raster_counter.sv
// ---------------------------------------------------------------------------
// fmap_raster_counter
//
// Raster position tracker for one NW x NH feature map. Holds the column (x),
// row (y) and a running read address that advances by one per issued read,
// so no multiplier is needed for base + y*NW + x.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_load       restart the raster at (0,0) with address i_base
//   i_step       one read was issued at the current position
//   i_base       frame base address
//   o_addr       registered address of the current position
//   o_row_end    current position is the last column of a row
//   o_frame_end  current position is the last pixel of the frame
// ---------------------------------------------------------------------------
module fmap_raster_counter
   import fmap_stream_pkg::*;
#(
   parameter int NW = 32,
   parameter int NH = 32,
   parameter int AW = 10
)
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load,
   input  logic          i_step,
   input  logic [AW-1:0] i_base,
   output logic [AW-1:0] o_addr,
   output logic          o_row_end,
   output logic          o_frame_end
);

   localparam int CW = cntWidth(NW, NH, 0);
   localparam logic [CW-1:0] X_LAST = CW'(NW - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(NH - 1);

   logic [CW-1:0] r_x;
   logic [CW-1:0] r_y;
   logic [AW-1:0] r_addr;

   assign o_addr      = r_addr;
   assign o_row_end   = (r_x == X_LAST);
   assign o_frame_end = o_row_end && (r_y == Y_LAST);

   // Position and address advance together on every issued read. The address
   // simply wraps modulo 2^AW, so a frame placed near the top of memory
   // continues from address 0 without any special handling.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
      end else if (i_load) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= i_base;
      end else if (i_step) begin
         r_addr <= r_addr + AW'(1);
         if (o_row_end) begin
            r_x <= '0;
            if (!o_frame_end) begin
               r_y <= r_y + CW'(1);
            end
         end else begin
            r_x <= r_x + CW'(1);
         end
      end
   end

endmodule

// File: rtl/fmap_stream_source.sv
// ---------------------------------------------------------------------------
// fmap_stream_source
//
// Streams one NW x NH feature map out of a 1-cycle-latency SRAM as a
// valid/D pixel stream toward the line-buffer window generator, inserting
// ROW_GAP idle cycles between rows and closing each frame with a one-cycle
// flush/done pulse.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      frame start request, honoured only in IDLE
//   i_base_addr  frame base address, captured when start is accepted
//   i_pause      hold off new memory reads (ignored during row gaps)
//   o_busy       frame in progress (any state other than IDLE)
//   o_done       one-cycle end-of-frame pulse, coincident with o_flush
//   o_mem_addr   SRAM read address (registered)
//   o_mem_ren    SRAM read enable
//   i_mem_rdata  SRAM read data, valid the cycle after o_mem_ren
//   o_valid      pixel valid toward the line buffer
//   o_flush      end-of-frame flush toward the line buffer
//   o_d          pixel data, forced to zero whenever o_valid is low
// ---------------------------------------------------------------------------
module fmap_stream_source
   import fmap_stream_pkg::*;
#(
   parameter int BITWIDTH = 8,
   parameter int NFMAPS   = 3,
   parameter int NW       = 32,
   parameter int NH       = 32,
   parameter int AW       = 10,
   parameter int ROW_GAP  = 1
)
(
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   input  logic [AW-1:0]                i_base_addr,
   input  logic                         i_pause,
   output logic                         o_busy,
   output logic                         o_done,
   output logic [AW-1:0]                o_mem_addr,
   output logic                         o_mem_ren,
   input  logic [NFMAPS*BITWIDTH-1:0]   i_mem_rdata,
   output logic                         o_valid,
   output logic                         o_flush,
   output logic [NFMAPS*BITWIDTH-1:0]   o_d
);

   localparam int GW = cntWidth(NW, NH, ROW_GAP);
   localparam logic [GW-1:0] GAP_LAST = (ROW_GAP > 0) ? GW'(ROW_GAP - 1) : '0;

   state_t        r_state;
   state_t        w_next;
   logic [GW-1:0] r_gap;
   logic          r_valid;
   logic          w_load;
   logic          w_step;
   logic          w_rowEnd;
   logic          w_frameEnd;

   // Raster bookkeeping lives in its own block; the FSM only tells it when a
   // frame is (re)loaded and when a read has actually gone out.
   fmap_raster_counter #(
      .NW (NW),
      .NH (NH),
      .AW (AW)
   ) u_raster (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (w_load),
      .i_step      (w_step),
      .i_base      (i_base_addr),
      .o_addr      (o_mem_addr),
      .o_row_end   (w_rowEnd),
      .o_frame_end (w_frameEnd)
   );

   // State register. Reset is asynchronous so a mid-frame reset drops every
   // control output in the same cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic. A read is issued only in READ with pause low, and the
   // row/frame transitions are tied to that issued read, so a pause on the
   // last pixel of a row simply postpones the whole transition.
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_step = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_load = 1'b1;
               w_next = ST_READ;
            end
         end
         ST_READ: begin
            if (!i_pause) begin
               w_step = 1'b1;
               if (w_rowEnd) begin
                  if (w_frameEnd) begin
                     w_next = ST_DRAIN;
                  end else if (ROW_GAP > 0) begin
                     w_next = ST_GAP;
                  end
               end
            end
         end
         ST_GAP: begin
            if (r_gap == GAP_LAST) begin
               w_next = ST_READ;
            end
         end
         ST_DRAIN: begin
            w_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Gap cycle counter: runs only while in GAP and is held at zero otherwise,
   // so each gap starts counting from a clean value.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_gap <= '0;
      end else if (r_state == ST_GAP) begin
         r_gap <= r_gap + GW'(1);
      end else begin
         r_gap <= '0;
      end
   end

   // valid tracks the SRAM's one-cycle read latency: it is the read enable
   // delayed by one cycle, so it lines up with the returned data.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_step;
      end
   end

   assign o_mem_ren = w_step;
   assign o_valid   = r_valid;
   assign o_d       = r_valid ? i_mem_rdata : '0;
   assign o_busy    = (r_state != ST_IDLE);
   assign o_flush   = (r_state == ST_FLUSH);
   assign o_done    = (r_state == ST_FLUSH);

endmodule

// File: doc/fmap_stream_source.md
Name: fmap_stream_source

Overview:
Feature-map streamer that drives the pixel-stream input of the line-buffer window generator.
- Reads one NW x NH input feature map, stored raster-order in a 1-cycle-latency SRAM, starting at a programmable base address.
- Emits pixels as a valid/D stream, with optional idle gap cycles between rows.
- Ends every frame with a single-cycle flush that resets the downstream line-buffer and SRAM controllers.
- Sits between the activation memory and the window generator; it is the transmitter end of the valid/flush/D protocol.

Parameters:
BITWIDTH, 8, bits per pixel per feature map
NFMAPS, 3, feature maps packed per word
NW, 32, pixels per row
NH, 32, rows per frame
AW, 10, memory address width
ROW_GAP, 1, idle cycles inserted between rows (0 allowed)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  frame start request, sampled in IDLE only
base_addr  in  AW  frame base address, latched when start is accepted
pause  in  1  suppress new memory reads while high
busy  out  1  high from the cycle after start is accepted until the cycle after done
done  out  1  one-cycle pulse, coincident with flush
mem_addr  out  AW  memory read address
mem_ren  out  1  memory read enable
mem_rdata  in  NFMAPS*BITWIDTH  read data, valid one cycle after mem_ren
valid  out  1  pixel valid toward line buffer
flush  out  1  end-of-frame flush, one cycle
D  out  NFMAPS*BITWIDTH  pixel data, equals mem_rdata whenever valid=1

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; counters 0; busy, done, mem_ren, valid, flush = 0; mem_addr = 0; D = 0 while valid=0 (gated).
- States: IDLE, READ, GAP, DRAIN, FLUSH.
- IDLE: start=1 -> latch base_addr, clear x/y, go to READ. busy=1 from the next cycle.
- READ:
  - mem_ren = !pause, combinational from state. mem_addr is registered and equals base + y*NW + x.
  - On each issued read: x++.
  - At x = NW-1 with y < NH-1: x←0, y++, then GAP if ROW_GAP>0, else stay in READ.
  - At x = NW-1 with y = NH-1: go to DRAIN.
  - pause=1 holds x, y and mem_addr; no read is issued.
- GAP: count ROW_GAP cycles with mem_ren=0, then return to READ. pause is ignored in GAP.
- DRAIN: one cycle; no read; the last pixel is emitted on valid.
- FLUSH: flush=1 and done=1 for exactly one cycle with valid=0, then IDLE. busy drops the following cycle.
- Output timing:
  - valid is mem_ren registered by one cycle; D = mem_rdata when valid=1, else 0.
  - valid and flush are never high in the same cycle.
- Latency: start sampled at cycle t → first mem_ren at t+1 (addr = base) → first valid at t+2.
- Frame cycle count with no pause: NW*NH + (NH-1)*ROW_GAP read/gap cycles, plus DRAIN, plus FLUSH.
- Address arithmetic: incremented modulo 2^AW. base + NW*NH may exceed 2^AW and wraps silently. No multiplier; a running address increments by 1 per read.
- start while busy is ignored. start in the FLUSH cycle is ignored. start in IDLE the cycle after FLUSH is accepted.
- Reset mid-frame: immediate return to IDLE. Any in-flight read is discarded; no valid, flush or done is emitted for it.
- pause asserted on the final read of a row: that read is deferred; the row transition happens only when the read actually issues.

Decomposition:
- Shared package fmap_stream_pkg: state enum (IDLE, READ, GAP, DRAIN, FLUSH) and a function giving counter width, clog2 of max(NW, NH, ROW_GAP+1).
- One sub-module, fmap_raster_counter, holds x, y and the running address. Inputs: load, step. Outputs: row_end, frame_end. The FSM stays in fmap_stream_source.

Test Plan:
1. Basic frame (NW=4, NH=3, ROW_GAP=1, base=0, start at cycle 0):
   - mem_ren at cycles 1–4, 6–9, 11–14 with addresses 0..11.
   - valid at cycles 2–5, 7–10, 12–15 with D matching the memory model.
   - flush=done=1 at cycle 16 only; busy high cycles 1–16.
2. Pause: same frame with pause=1 at cycles 2–3 → addr 1 issued at cycle 4. Every later event shifts by +2; no pixel is duplicated or dropped (12 valids total).
3. Wrap: base=1020, AW=10 → addresses 1020,1021,1022,1023,0,1,...,7 in order.
4. Start while busy: pulse start again at cycle 5 with base=100 → ignored, addresses unchanged. A start at cycle 17 (IDLE) is accepted with base=100.
5. Reset mid-frame: rst=1 at cycle 7 → all outputs 0 the same cycle. No flush or done afterward; a new start after reset produces a full clean frame from the new base.
6. ROW_GAP=0, NW=1, NH=1: single read at cycle 1, valid at 2, DRAIN, then flush/done at 3.
